// File: rtl/ibuf_stream.sv
// Input window buffer: shifts a lanes-wide activation stream into a fifo_length-deep
// window and holds the completed window for the crossbar row drivers until consumed.
module ibuf_stream #(
   parameter int datatype_size = 8,
   parameter int fifo_length   = 720,
   parameter int lanes         = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                i_valid,
   output logic                                o_ready,
   input  logic [datatype_size-1:0]            i_data [lanes],
   input  logic                                i_consume,
   input  logic                                i_clear,
   output logic                                o_valid,
   output logic [$clog2(fifo_length+1)-1:0]    o_count,
   output logic [datatype_size-1:0]            o_data [fifo_length]
);

   localparam int CW = $clog2(fifo_length + 1);
   localparam logic [CW-1:0] LANES_C = CW'(lanes);
   localparam logic [CW-1:0] DEPTH_C = CW'(fifo_length);

   generate
      if (lanes < 1 || (fifo_length % lanes) != 0) begin : g_param_chk
         $error("ibuf_stream: fifo_length must be a positive multiple of lanes");
      end
   endgenerate

   typedef enum logic {S_FILL, S_FULL} state_t;

   state_t                   state, state_nxt;
   logic [CW-1:0]            count, count_nxt;
   logic [datatype_size-1:0] fifo     [fifo_length];
   logic [datatype_size-1:0] fifo_nxt [fifo_length];
   logic                     accept;

   assign o_ready = !i_clear && (state == S_FILL || i_consume);
   assign accept  = i_valid && o_ready;

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      if (i_clear) begin
         state_nxt = S_FILL;
         count_nxt = '0;
      end else begin
         case (state)
            S_FILL: begin
               if (accept) begin
                  count_nxt = count + LANES_C;
                  if (count + LANES_C == DEPTH_C)
                     state_nxt = S_FULL;
               end
            end
            S_FULL: begin
               // Consume with a same-cycle beat starts the next window without a bubble
               if (i_consume) begin
                  count_nxt = accept ? LANES_C : '0;
                  state_nxt = (accept && lanes == fifo_length) ? S_FULL : S_FILL;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      fifo_nxt = fifo;
      if (i_clear) begin
         for (int unsigned j = 0; j < unsigned'(fifo_length); j++)
            fifo_nxt[j] = '0;
      end else if (accept) begin
         for (int unsigned j = unsigned'(lanes); j < unsigned'(fifo_length); j++)
            fifo_nxt[j] = fifo[j - unsigned'(lanes)];
         for (int unsigned j = 0; j < unsigned'(lanes); j++)
            fifo_nxt[j] = i_data[unsigned'(lanes) - 1 - j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FILL;
         count <= '0;
         for (int unsigned j = 0; j < unsigned'(fifo_length); j++)
            fifo[j] <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         fifo  <= fifo_nxt;
      end
   end

   assign o_valid = (state == S_FULL);
   assign o_count = count;

   always_comb o_data = fifo;

endmodule

// File: tb/tb_ibuf_stream.sv
// Directed and scoreboarded checks of ibuf_stream with depth 8, for lanes=1 and lanes=4.
module tb_ibuf_stream;

   localparam int DW = 8;
   localparam int FL = 8;
   localparam int CW = $clog2(FL + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic          v1, cons1, clr1, r1, ov1;
   logic [DW-1:0] d1 [1];
   logic [CW-1:0] cnt1;
   logic [DW-1:0] q1 [FL];

   logic          v4, cons4, clr4, r4, ov4;
   logic [DW-1:0] d4 [4];
   logic [CW-1:0] cnt4;
   logic [DW-1:0] q4 [FL];

   ibuf_stream #(.datatype_size(DW), .fifo_length(FL), .lanes(1)) u1 (
      .clk(clk), .rst_n(rst_n), .i_valid(v1), .o_ready(r1), .i_data(d1),
      .i_consume(cons1), .i_clear(clr1), .o_valid(ov1), .o_count(cnt1), .o_data(q1)
   );

   ibuf_stream #(.datatype_size(DW), .fifo_length(FL), .lanes(4)) u4 (
      .clk(clk), .rst_n(rst_n), .i_valid(v4), .o_ready(r4), .i_data(d4),
      .i_consume(cons4), .i_clear(clr4), .o_valid(ov4), .o_count(cnt4), .o_data(q4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             v;
      logic             c;
      logic             clr;
      logic [3:0][7:0]  d;
      logic             er;
      logic             ev;
      int               ecnt;
      logic [7:0][7:0]  ed;
   } vec_t;

   vec_t vq [$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [3:0][7:0] b4(input int a, input int b, input int c, input int d);
      logic [3:0][7:0] r;
      r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
      return r;
   endfunction

   function automatic logic [7:0][7:0] w8(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
      logic [7:0][7:0] r;
      r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
      r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
      return r;
   endfunction

   task automatic addv(input logic v, input logic c, input logic clr, input logic [3:0][7:0] d,
                       input logic er, input logic ev, input int ecnt, input logic [7:0][7:0] ed);
      vec_t t;
      t.v = v; t.c = c; t.clr = clr; t.d = d;
      t.er = er; t.ev = ev; t.ecnt = ecnt; t.ed = ed;
      vq.push_back(t);
   endtask

   initial begin
      logic [7:0] hist [$];
      logic       mfull, exp_r, acc;
      int         mcnt, windows, cyc;

      v1 = 0; cons1 = 0; clr1 = 0; d1[0] = '0;
      v4 = 0; cons4 = 0; clr4 = 0;
      for (int k = 0; k < 4; k++) d4[k] = '0;

      // inputs, then expected o_ready before the edge and state after it
      addv(0,0,0, b4(0,0,0,0),      1,0,0, w8(0,0,0,0,0,0,0,0));
      addv(1,0,0, b4(1,2,3,4),      1,0,4, w8(4,3,2,1,0,0,0,0));
      addv(1,0,0, b4(5,6,7,8),      1,1,8, w8(8,7,6,5,4,3,2,1));
      addv(1,0,0, b4(99,99,99,99),  0,1,8, w8(8,7,6,5,4,3,2,1));
      addv(1,1,0, b4(9,10,11,12),   1,0,4, w8(12,11,10,9,8,7,6,5));
      addv(1,0,1, b4(13,14,15,16),  0,0,0, w8(0,0,0,0,0,0,0,0));
      addv(1,0,0, b4(1,2,3,4),      1,0,4, w8(4,3,2,1,0,0,0,0));
      addv(1,0,0, b4(5,6,7,8),      1,1,8, w8(8,7,6,5,4,3,2,1));
      addv(0,1,1, b4(0,0,0,0),      0,0,0, w8(0,0,0,0,0,0,0,0));
      addv(1,0,0, b4(21,22,23,24),  1,0,4, w8(24,23,22,21,0,0,0,0));
      addv(1,0,0, b4(25,26,27,28),  1,1,8, w8(28,27,26,25,24,23,22,21));
      addv(0,1,0, b4(0,0,0,0),      1,0,0, w8(28,27,26,25,24,23,22,21));
      addv(0,1,0, b4(0,0,0,0),      1,0,0, w8(28,27,26,25,24,23,22,21));
      addv(1,1,0, b4(1,2,3,4),      1,0,4, w8(4,3,2,1,28,27,26,25));

      #12;
      chk("rst u4 valid", 32'(ov4), 0);
      chk("rst u4 count", 32'(cnt4), 0);
      chk("rst u4 ready", 32'(r4), 1);
      chk("rst u1 valid", 32'(ov1), 0);
      chk("rst u1 count", 32'(cnt1), 0);
      chk("rst u1 ready", 32'(r1), 1);
      for (int j = 0; j < FL; j++) begin
         chk($sformatf("rst u4 data[%0d]", j), 32'(q4[j]), 0);
         chk($sformatf("rst u1 data[%0d]", j), 32'(q1[j]), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vq[i]) begin
         v4 = vq[i].v; cons4 = vq[i].c; clr4 = vq[i].clr;
         for (int k = 0; k < 4; k++) d4[k] = vq[i].d[k];
         #1;
         chk($sformatf("vec%0d ready", i), 32'(r4), 32'(vq[i].er));
         @(posedge clk); #1;
         chk($sformatf("vec%0d valid", i), 32'(ov4), 32'(vq[i].ev));
         chk($sformatf("vec%0d count", i), 32'(cnt4), 32'(vq[i].ecnt));
         for (int j = 0; j < FL; j++)
            chk($sformatf("vec%0d data[%0d]", i, j), 32'(q4[j]), 32'(vq[i].ed[j]));
      end

      // asynchronous reset mid-fill (u4 holds 4 words here)
      v4 = 0; cons4 = 0; clr4 = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("async rst count", 32'(cnt4), 0);
      chk("async rst valid", 32'(ov4), 0);
      for (int j = 0; j < FL; j++)
         chk($sformatf("async rst data[%0d]", j), 32'(q4[j]), 0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // lanes=1: stream 1..8 back to back
      for (int k = 1; k <= FL; k++) begin
         v1 = 1; d1[0] = 8'(k);
         #1;
         chk($sformatf("l1 ready beat%0d", k), 32'(r1), 1);
         @(posedge clk); #1;
         chk($sformatf("l1 count beat%0d", k), 32'(cnt1), 32'(k));
         chk($sformatf("l1 valid beat%0d", k), 32'(ov1), (k == FL) ? 1 : 0);
      end
      for (int j = 0; j < FL; j++)
         chk($sformatf("l1 window[%0d]", j), 32'(q1[j]), 32'(FL - j));
      d1[0] = 8'd9;
      #1;
      chk("l1 ready held full", 32'(r1), 0);
      @(posedge clk); #1;
      chk("l1 valid held", 32'(ov1), 1);
      chk("l1 count held", 32'(cnt1), 8);
      for (int j = 0; j < FL; j++)
         chk($sformatf("l1 frozen[%0d]", j), 32'(q1[j]), 32'(FL - j));
      cons1 = 1;
      #1;
      chk("l1 ready consume", 32'(r1), 1);
      @(posedge clk); #1;
      chk("l1 valid after consume", 32'(ov1), 0);
      chk("l1 count after consume", 32'(cnt1), 1);
      chk("l1 data0 after consume", 32'(q1[0]), 9);
      chk("l1 data7 after consume", 32'(q1[7]), 2);
      v1 = 0; cons1 = 0;

      // lanes=4 random backpressure against a stream scoreboard
      mfull = 0; mcnt = 0; windows = 0; cyc = 0;
      @(posedge clk); #1;
      while (windows < 50 && cyc < 4000) begin
         cyc++;
         v4    = ($urandom_range(0, 3) != 0);
         cons4 = ($urandom_range(0, 2) == 0);
         clr4  = 0;
         for (int k = 0; k < 4; k++) d4[k] = 8'($urandom_range(0, 255));
         exp_r = !mfull || cons4;
         #1;
         chk("rnd ready", 32'(r4), 32'(exp_r));
         acc = v4 && exp_r;
         if (acc)
            for (int k = 0; k < 4; k++) hist.push_back(d4[k]);
         while (hist.size() > FL) void'(hist.pop_front());
         if (mfull) begin
            if (cons4) begin
               mfull = 0;
               mcnt  = acc ? 4 : 0;
            end
         end else if (acc) begin
            mcnt += 4;
            if (mcnt == FL) begin
               mfull = 1;
               windows++;
            end
         end
         @(posedge clk); #1;
         chk("rnd valid", 32'(ov4), 32'(mfull));
         chk("rnd count", 32'(cnt4), 32'(mcnt));
         if (mfull)
            for (int j = 0; j < FL; j++)
               chk($sformatf("rnd win%0d[%0d]", windows, j), 32'(q4[j]),
                   32'(hist[hist.size() - 1 - j]));
      end
      chk("rnd windows completed", 32'(windows), 50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ibuf_stream.md
# ibuf_stream

Parametrised input buffer that gathers a stream of activation words into a `fifo_length`-deep shift register and presents the whole window in parallel to the crossbar input drivers. Words arrive `lanes` at a time under a valid/ready handshake. The buffer reports when the window is complete and holds it stable until the consumer releases it. It sits between the host/DMA input stream and the CIM tile's row drivers.

## Interface
- `datatype_size`, 8, bits per word
- `fifo_length`, 720, window depth in words; must be a multiple of `lanes` (elaboration error otherwise)
- `lanes`, 1, words accepted per handshake beat (≥1)
- `clk`  input  1  clock, rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `i_valid`  input  1  input beat valid
- `o_ready`  output  1  buffer can accept a beat this cycle
- `i_data`  input  `datatype_size` × [`lanes`]  beat words; `i_data[0]` is earliest in stream order
- `i_consume`  input  1  consumer releases the full window
- `i_clear`  input  1  synchronous flush
- `o_valid`  output  1  window complete and stable
- `o_count`  output  `$clog2(fifo_length+1)`  words held in the current window
- `o_data`  output  `datatype_size` × [`fifo_length`]  window; index 0 is the newest word

## Operation
- States: FILL (accepting), FULL (window held).
- Accept = `i_valid && o_ready`.
- `o_ready = !i_clear && (state==FILL || i_consume)`, combinational.
- Shift on accept, equivalent to `lanes` sequential single-word writes of `i_data[0]`, then `i_data[1]`, and so on:
  - `fifo[j] <= i_data[lanes-1-j]` for j < `lanes`
  - `fifo[j] <= fifo[j-lanes]` otherwise
  - Words shifted past index `fifo_length-1` are discarded.
- FILL:
  - Each accept adds `lanes` to the count.
  - When an accept brings the count to `fifo_length`, go to FULL.
- FULL:
  - `o_valid=1`; `o_data` is frozen.
  - `i_consume` without accept: go to FILL, count=0. Data is not cleared.
  - `i_consume` with accept (same cycle): the beat is shifted in, count=`lanes`, state FILL. If `lanes==fifo_length`, stay in FULL.
  - `i_consume` in FILL is ignored.
- `i_clear` has highest priority:
  - Next cycle: all fifo words 0, count 0, state FILL.
  - No beat is accepted that cycle.
- `o_valid = (state==FULL)`, registered.
- Reset state (asynchronous, while `rst_n`=0):
  - state FILL, count 0, all `o_data` words 0, `o_valid` 0.
  - `o_ready` follows its equation, so it is 1 once `i_clear`=0.

## Timing
- Latency: an accepted beat is visible on `o_data` and `o_count` one cycle after the accepting edge.
- `o_valid` rises on the same edge that stores the final beat.
- Throughput:
  - One beat per cycle in FILL.
  - With `i_consume` asserted while `o_valid`=1 and `i_valid`=1, no bubble between windows.
- `o_ready` depends combinationally on `i_consume` and `i_clear`. No combinational path from `i_valid` to any output.
- Reset deassertion mid-stream: the buffer restarts an empty window. A partial window held before reset is lost.
- `i_consume` and `i_clear` together: clear wins and no beat is accepted.

## Test plan
- Reset, then check outputs:
  - `o_valid=0`, `o_count=0`, all `o_data=0`, `o_ready=1`.
  - Assert `rst_n`=0 mid-fill (count 4) → count 0 and data 0 immediately, without waiting for a clock edge.
- `fifo_length=8`, `lanes=1`, stream values 1..8 with back-to-back valid:
  - `o_valid` rises after the 8th accept.
  - `o_data[0]=8` … `o_data[7]=1`.
  - `o_ready=0` while a 9th value is held on `i_valid`; `o_data` unchanged.
- `fifo_length=8`, `lanes=4`, beats {1,2,3,4} then {5,6,7,8}:
  - After beat 1: `o_count=4`.
  - After beat 2: `o_valid=1`, `o_data[0..7]=8,7,6,5,4,3,2,1`.
- While FULL, assert `i_consume` together with `i_valid` and beat {9,10,11,12}:
  - Same-cycle accept.
  - Next cycle `o_valid=0`, `o_count=4`, `o_data[0..3]=12,11,10,9`, `o_data[4..7]=8,7,6,5`.
- `i_clear` at count 4 with `i_valid=1`:
  - `o_ready=0` that cycle.
  - Next cycle count 0 and all data 0.
  - Also `i_clear` with `i_consume` in FULL → FILL, count 0.
- Random valid/consume backpressure over 50 windows:
  - A scoreboard checks every completed window equals the last `fifo_length` accepted words.
  - No beat is accepted while FULL without `i_consume`.
